// File: rtl/axi_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module   : axi_slave_mem
//  Purpose  : AXI4 slave memory model. Responds to master-driven bursts
//             (FIXED / INCR / WRAP), handles narrow and unaligned transfers
//             with byte-lane mapping, and reports SLVERR on illegal bursts,
//             out-of-range beats and w_last misplacement.
//  Ports    : clk, reset (async, active low)
//             AW : aw_addr/len/size/burst/valid -> aw_ready
//             W  : w_data/strb/last/valid       -> w_ready
//             B  : b_resp/b_valid               <- b_ready
//             AR : ar_addr/len/size/burst/valid -> ar_ready
//             R  : r_data/resp/last/valid       <- r_ready
//  Revision : 1.0 - initial release
// ============================================================================
module axi_slave_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int STRB_WIDTH = DATA_WIDTH/8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           aw_addr,
   input  logic [7:0]            aw_len,
   input  logic [2:0]            aw_size,
   input  logic [1:0]            aw_burst,
   input  logic                  aw_valid,
   output logic                  aw_ready,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic [STRB_WIDTH-1:0] w_strb,
   input  logic                  w_last,
   input  logic                  w_valid,
   output logic                  w_ready,
   output logic [1:0]            b_resp,
   output logic                  b_valid,
   input  logic                  b_ready,
   input  logic [31:0]           ar_addr,
   input  logic [7:0]            ar_len,
   input  logic [2:0]            ar_size,
   input  logic [1:0]            ar_burst,
   input  logic                  ar_valid,
   output logic                  ar_ready,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic [1:0]            r_resp,
   output logic                  r_last,
   output logic                  r_valid,
   input  logic                  r_ready
);

   localparam int         c_LANE_W    = $clog2(STRB_WIDTH);
   localparam int         c_MEM_BYTES = 2**ADDR_WIDTH;
   localparam logic [1:0] c_OKAY      = 2'b00;
   localparam logic [1:0] c_SLVERR    = 2'b10;
   localparam logic [1:0] c_FIXED     = 2'b00;
   localparam logic [1:0] c_WRAP      = 2'b10;

   // ---------------------------------------------------------------- helpers
   function automatic logic [31:0] f_align(input logic [31:0] a, input logic [2:0] sz);
      return a & ~((32'd1 << sz) - 32'd1);
   endfunction

   // T-1 where T is the total wrap span in bytes
   function automatic logic [31:0] f_wrap_mask(input logic [7:0] len, input logic [2:0] sz);
      return (({24'd0, len} + 32'd1) << sz) - 32'd1;
   endfunction

   function automatic logic [31:0] f_next(input logic [31:0] a, input logic [2:0] sz,
                                          input logic [1:0] b, input logic [31:0] m);
      logic [31:0] inc;
      logic [31:0] res;
      inc = a + (32'd1 << sz);
      if (b == c_FIXED)     res = a;
      else if (b == c_WRAP) res = (a & ~m) | (inc & m);
      else                  res = inc;
      return res;
   endfunction

   // Burst-level errors that apply to every beat
   function automatic logic f_cfg_err(input logic [31:0] a, input logic [7:0] len,
                                      input logic [2:0] sz, input logic [1:0] b);
      logic e;
      e = ({29'd0, sz} > 32'(c_LANE_W)) || (b == 2'b11);
      if (b == c_WRAP)
         e = e || !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
               || ((a & ((32'd1 << sz) - 32'd1)) != 32'd0);
      return e;
   endfunction

   // Beat addresses are size-aligned and size never exceeds the memory, so
   // checking the first byte covers the whole beat.
   function automatic logic f_oob(input logic [31:0] a);
      return (a >> ADDR_WIDTH) != 32'd0;
   endfunction

   function automatic logic [STRB_WIDTH-1:0] f_lanes(input logic [31:0] a, input logic [2:0] sz);
      logic [STRB_WIDTH-1:0] en;
      int                    base;
      int                    nb;
      base = int'(a[c_LANE_W-1:0]);
      nb   = 1 << sz;
      for (int l = 0; l < STRB_WIDTH; l++)
         en[l] = (l >= base) && (l < base + nb);
      return en;
   endfunction

   // ----------------------------------------------------------------- storage
   logic [7:0] r_mem [c_MEM_BYTES];

   // ============================================================ write channel
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;

   wstate_t     r_wstate,   w_wstate_nx;
   logic        r_aw_ready, w_aw_ready_nx;
   logic        r_w_ready,  w_w_ready_nx;
   logic        r_b_valid,  w_b_valid_nx;
   logic [1:0]  r_b_resp,   w_b_resp_nx;
   logic [31:0] r_waddr,    w_waddr_nx;
   logic [31:0] r_wmask,    w_wmask_nx;
   logic [7:0]  r_wlen,     w_wlen_nx;
   logic [2:0]  r_wsize,    w_wsize_nx;
   logic [1:0]  r_wburst,   w_wburst_nx;
   logic [7:0]  r_wbeat,    w_wbeat_nx;
   logic        r_wcfg_err, w_wcfg_err_nx;
   logic        r_werr,     w_werr_nx;

   logic                  w_w_hs;
   logic                  w_wbeat_err;
   logic                  w_wlast_bad;
   logic [STRB_WIDTH-1:0] w_wlanes;

   assign w_w_hs      = r_w_ready & w_valid;
   assign w_wbeat_err = r_wcfg_err | f_oob(r_waddr);
   assign w_wlast_bad = w_last != (r_wbeat == r_wlen);
   assign w_wlanes    = f_lanes(r_waddr, r_wsize) & w_strb;

   always_comb begin
      w_wstate_nx   = r_wstate;
      w_aw_ready_nx = r_aw_ready;
      w_w_ready_nx  = r_w_ready;
      w_b_valid_nx  = r_b_valid;
      w_b_resp_nx   = r_b_resp;
      w_waddr_nx    = r_waddr;
      w_wmask_nx    = r_wmask;
      w_wlen_nx     = r_wlen;
      w_wsize_nx    = r_wsize;
      w_wburst_nx   = r_wburst;
      w_wbeat_nx    = r_wbeat;
      w_wcfg_err_nx = r_wcfg_err;
      w_werr_nx     = r_werr;
      case (r_wstate)
         W_IDLE: begin
            w_aw_ready_nx = 1'b1;
            if (aw_valid && r_aw_ready) begin
               w_aw_ready_nx = 1'b0;
               w_w_ready_nx  = 1'b1;
               w_waddr_nx    = f_align(aw_addr, aw_size);
               w_wmask_nx    = f_wrap_mask(aw_len, aw_size);
               w_wlen_nx     = aw_len;
               w_wsize_nx    = aw_size;
               w_wburst_nx   = aw_burst;
               w_wbeat_nx    = 8'd0;
               w_wcfg_err_nx = f_cfg_err(aw_addr, aw_len, aw_size, aw_burst);
               w_werr_nx     = 1'b0;
               w_wstate_nx   = W_DATA;
            end
         end
         W_DATA: begin
            if (w_w_hs) begin
               w_werr_nx  = r_werr | w_wbeat_err | w_wlast_bad;
               w_wbeat_nx = r_wbeat + 8'd1;
               w_waddr_nx = f_next(r_waddr, r_wsize, r_wburst, r_wmask);
               // Beat count, not w_last, ends the burst
               if (r_wbeat == r_wlen) begin
                  w_w_ready_nx = 1'b0;
                  w_b_valid_nx = 1'b1;
                  w_b_resp_nx  = w_werr_nx ? c_SLVERR : c_OKAY;
                  w_wstate_nx  = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (b_ready) begin
               w_b_valid_nx  = 1'b0;
               w_b_resp_nx   = c_OKAY;
               w_aw_ready_nx = 1'b1;
               w_wstate_nx   = W_IDLE;
            end
         end
         default: w_wstate_nx = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wstate   <= W_IDLE;
         r_aw_ready <= 1'b0;
         r_w_ready  <= 1'b0;
         r_b_valid  <= 1'b0;
         r_b_resp   <= c_OKAY;
         r_waddr    <= '0;
         r_wmask    <= '0;
         r_wlen     <= '0;
         r_wsize    <= '0;
         r_wburst   <= '0;
         r_wbeat    <= '0;
         r_wcfg_err <= 1'b0;
         r_werr     <= 1'b0;
      end else begin
         r_wstate   <= w_wstate_nx;
         r_aw_ready <= w_aw_ready_nx;
         r_w_ready  <= w_w_ready_nx;
         r_b_valid  <= w_b_valid_nx;
         r_b_resp   <= w_b_resp_nx;
         r_waddr    <= w_waddr_nx;
         r_wmask    <= w_wmask_nx;
         r_wlen     <= w_wlen_nx;
         r_wsize    <= w_wsize_nx;
         r_wburst   <= w_wburst_nx;
         r_wbeat    <= w_wbeat_nx;
         r_wcfg_err <= w_wcfg_err_nx;
         r_werr     <= w_werr_nx;
      end
   end

   // Memory has no reset; an asserted reset drops w_ready at once, so no
   // beat of an abandoned burst can land.
   always_ff @(posedge clk) begin
      if (w_w_hs && !w_wbeat_err) begin
         for (int l = 0; l < STRB_WIDTH; l++) begin
            if (w_wlanes[l])
               r_mem[{r_waddr[ADDR_WIDTH-1:c_LANE_W], l[c_LANE_W-1:0]}] <= w_data[8*l +: 8];
         end
      end
   end

   // ============================================================= read channel
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

   rstate_t               r_rstate,   w_rstate_nx;
   logic                  r_ar_ready, w_ar_ready_nx;
   logic                  r_r_valid,  w_r_valid_nx;
   logic [DATA_WIDTH-1:0] r_r_data,   w_r_data_nx;
   logic [1:0]            r_r_resp,   w_r_resp_nx;
   logic                  r_r_last,   w_r_last_nx;
   logic [31:0]           r_raddr,    w_raddr_nx;
   logic [31:0]           r_rmask,    w_rmask_nx;
   logic [7:0]            r_rlen,     w_rlen_nx;
   logic [2:0]            r_rsize,    w_rsize_nx;
   logic [1:0]            r_rburst,   w_rburst_nx;
   logic [7:0]            r_rbeat,    w_rbeat_nx;
   logic                  r_rcfg_err, w_rcfg_err_nx;

   logic                  w_ar_cfg_err;
   logic [31:0]           w_ld_addr;
   logic [2:0]            w_ld_size;
   logic                  w_ld_err;
   logic [STRB_WIDTH-1:0] w_ld_lanes;
   logic [DATA_WIDTH-1:0] w_ld_data;

   assign w_ar_cfg_err = f_cfg_err(ar_addr, ar_len, ar_size, ar_burst);

   // Beat loader: in idle it fetches beat 0 straight from the AR request so
   // r_valid can rise the cycle after the handshake; in R_DATA it prefetches
   // the following beat so consecutive beats need no bubble. Reading the
   // array combinationally gives read-first behaviour against a same-edge write.
   always_comb begin
      if (r_rstate == R_IDLE) begin
         w_ld_addr = f_align(ar_addr, ar_size);
         w_ld_size = ar_size;
         w_ld_err  = w_ar_cfg_err | f_oob(w_ld_addr);
      end else begin
         w_ld_addr = f_next(r_raddr, r_rsize, r_rburst, r_rmask);
         w_ld_size = r_rsize;
         w_ld_err  = r_rcfg_err | f_oob(w_ld_addr);
      end
      w_ld_lanes = f_lanes(w_ld_addr, w_ld_size);
      w_ld_data  = '0;
      for (int l = 0; l < STRB_WIDTH; l++) begin
         if (w_ld_lanes[l] && !w_ld_err)
            w_ld_data[8*l +: 8] = r_mem[{w_ld_addr[ADDR_WIDTH-1:c_LANE_W], l[c_LANE_W-1:0]}];
      end
   end

   always_comb begin
      w_rstate_nx   = r_rstate;
      w_ar_ready_nx = r_ar_ready;
      w_r_valid_nx  = r_r_valid;
      w_r_data_nx   = r_r_data;
      w_r_resp_nx   = r_r_resp;
      w_r_last_nx   = r_r_last;
      w_raddr_nx    = r_raddr;
      w_rmask_nx    = r_rmask;
      w_rlen_nx     = r_rlen;
      w_rsize_nx    = r_rsize;
      w_rburst_nx   = r_rburst;
      w_rbeat_nx    = r_rbeat;
      w_rcfg_err_nx = r_rcfg_err;
      case (r_rstate)
         R_IDLE: begin
            w_ar_ready_nx = 1'b1;
            if (ar_valid && r_ar_ready) begin
               w_ar_ready_nx = 1'b0;
               w_r_valid_nx  = 1'b1;
               w_r_data_nx   = w_ld_data;
               w_r_resp_nx   = w_ld_err ? c_SLVERR : c_OKAY;
               w_r_last_nx   = (ar_len == 8'd0);
               w_raddr_nx    = w_ld_addr;
               w_rmask_nx    = f_wrap_mask(ar_len, ar_size);
               w_rlen_nx     = ar_len;
               w_rsize_nx    = ar_size;
               w_rburst_nx   = ar_burst;
               w_rbeat_nx    = 8'd0;
               w_rcfg_err_nx = w_ar_cfg_err;
               w_rstate_nx   = R_DATA;
            end
         end
         R_DATA: begin
            if (r_ready) begin
               if (r_r_last) begin
                  w_r_valid_nx  = 1'b0;
                  w_r_last_nx   = 1'b0;
                  w_r_data_nx   = '0;
                  w_r_resp_nx   = c_OKAY;
                  w_ar_ready_nx = 1'b1;
                  w_rstate_nx   = R_IDLE;
               end else begin
                  w_r_data_nx = w_ld_data;
                  w_r_resp_nx = w_ld_err ? c_SLVERR : c_OKAY;
                  w_r_last_nx = ((r_rbeat + 8'd1) == r_rlen);
                  w_raddr_nx  = w_ld_addr;
                  w_rbeat_nx  = r_rbeat + 8'd1;
               end
            end
         end
         default: w_rstate_nx = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rstate   <= R_IDLE;
         r_ar_ready <= 1'b0;
         r_r_valid  <= 1'b0;
         r_r_data   <= '0;
         r_r_resp   <= c_OKAY;
         r_r_last   <= 1'b0;
         r_raddr    <= '0;
         r_rmask    <= '0;
         r_rlen     <= '0;
         r_rsize    <= '0;
         r_rburst   <= '0;
         r_rbeat    <= '0;
         r_rcfg_err <= 1'b0;
      end else begin
         r_rstate   <= w_rstate_nx;
         r_ar_ready <= w_ar_ready_nx;
         r_r_valid  <= w_r_valid_nx;
         r_r_data   <= w_r_data_nx;
         r_r_resp   <= w_r_resp_nx;
         r_r_last   <= w_r_last_nx;
         r_raddr    <= w_raddr_nx;
         r_rmask    <= w_rmask_nx;
         r_rlen     <= w_rlen_nx;
         r_rsize    <= w_rsize_nx;
         r_rburst   <= w_rburst_nx;
         r_rbeat    <= w_rbeat_nx;
         r_rcfg_err <= w_rcfg_err_nx;
      end
   end

   // ------------------------------------------------------------------ outputs
   assign aw_ready = r_aw_ready;
   assign w_ready  = r_w_ready;
   assign b_valid  = r_b_valid;
   assign b_resp   = r_b_resp;
   assign ar_ready = r_ar_ready;
   assign r_valid  = r_r_valid;
   assign r_data   = r_r_data;
   assign r_resp   = r_r_resp;
   assign r_last   = r_r_last;

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_slave_mem
//  Purpose  : Directed self-checking bench for axi_slave_mem (32-bit data,
//             256-byte memory). Expected values are hand-computed constants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_slave_mem;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int SW = DW/8;
   localparam logic [1:0] INCR = 2'b01;
   localparam logic [1:0] WRAP = 2'b10;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [31:0]   aw_addr = '0;
   logic [7:0]    aw_len = '0;
   logic [2:0]    aw_size = '0;
   logic [1:0]    aw_burst = '0;
   logic          aw_valid = 1'b0;
   logic          aw_ready;
   logic [DW-1:0] w_data = '0;
   logic [SW-1:0] w_strb = '0;
   logic          w_last = 1'b0;
   logic          w_valid = 1'b0;
   logic          w_ready;
   logic [1:0]    b_resp;
   logic          b_valid;
   logic          b_ready = 1'b0;
   logic [31:0]   ar_addr = '0;
   logic [7:0]    ar_len = '0;
   logic [2:0]    ar_size = '0;
   logic [1:0]    ar_burst = '0;
   logic          ar_valid = 1'b0;
   logic          ar_ready;
   logic [DW-1:0] r_data;
   logic [1:0]    r_resp;
   logic          r_last;
   logic          r_valid;
   logic          r_ready = 1'b0;

   always #5 clk = ~clk;

   axi_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
      .clk(clk), .reset(reset),
      .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
      .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
      .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
      .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
      .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready)
   );

   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] tb_wd [16];
   logic [3:0]  tb_ws [16];
   logic        tb_wl [16];
   logic [31:0] rd_data [16];
   logic [1:0]  rd_resp [16];
   logic        rd_last [16];
   logic [1:0]  wr_resp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Default beat table: full strobes, w_last on the final beat only
   task automatic set_wr(input int len);
      for (int k = 0; k < 16; k++) begin
         tb_ws[k] = 4'hF;
         tb_wl[k] = (k == len);
      end
   endtask

   // All channel tasks start and end on a falling edge
   task automatic aw_hs(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
      int t = 0;
      aw_addr = a; aw_len = l; aw_size = s; aw_burst = b; aw_valid = 1'b1;
      while (!aw_ready && t < 50) begin @(negedge clk); t++; end
      if (!aw_ready) chk("aw_timeout", 0, 1);
      @(negedge clk);
      aw_valid = 1'b0;
   endtask

   task automatic w_beat(input logic [31:0] d, input logic [3:0] st, input logic last);
      int t = 0;
      w_data = d; w_strb = st; w_last = last; w_valid = 1'b1;
      while (!w_ready && t < 50) begin @(negedge clk); t++; end
      if (!w_ready) chk("w_timeout", 0, 1);
      @(negedge clk);
      w_valid = 1'b0; w_last = 1'b0;
   endtask

   task automatic b_get(input int stall, output logic [1:0] resp);
      int t = 0;
      while (!b_valid && t < 50) begin @(negedge clk); t++; end
      if (!b_valid) chk("b_timeout", 0, 1);
      for (int i = 0; i < stall; i++) begin
         chk("b_hold_valid_awready", {b_valid, aw_ready}, 2'b10);
         @(negedge clk);
      end
      resp = b_resp;
      b_ready = 1'b1;
      @(negedge clk);
      b_ready = 1'b0;
      chk("b_done_awready_bvalid", {aw_ready, b_valid}, 2'b10);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input int bstall, output logic [1:0] resp);
      aw_hs(a, l, s, b);
      for (int k = 0; k <= int'(l); k++) w_beat(tb_wd[k], tb_ws[k], tb_wl[k]);
      b_get(bstall, resp);
   endtask

   task automatic ar_hs(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
      int t = 0;
      ar_addr = a; ar_len = l; ar_size = s; ar_burst = b; ar_valid = 1'b1;
      while (!ar_ready && t < 50) begin @(negedge clk); t++; end
      if (!ar_ready) chk("ar_timeout", 0, 1);
      @(negedge clk);
      ar_valid = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input int stall_beat, input int stall_n,
                          input logic [31:0] exp_hold);
      ar_hs(a, l, s, b);
      r_ready = 1'b0;
      for (int k = 0; k <= int'(l); k++) begin
         int t = 0;
         while (!r_valid && t < 50) begin @(negedge clk); t++; end
         if (!r_valid) chk("r_timeout", 0, 1);
         if (k == stall_beat) begin
            r_ready = 1'b0;
            for (int i = 0; i < stall_n; i++) begin
               chk("r_hold_valid_data", {r_valid, r_data}, {1'b1, exp_hold});
               @(negedge clk);
            end
         end
         rd_data[k] = r_data;
         rd_resp[k] = r_resp;
         rd_last[k] = r_last;
         r_ready = 1'b1;
         @(negedge clk);
      end
      r_ready = 1'b0;
      chk("r_done_valid_last_arready", {r_valid, r_last, ar_ready}, 3'b001);
   endtask

   initial begin
      // ---------------- reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs", {aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last, r_resp, b_resp, r_data}, 64'd0);
      reset = 1'b1;
      #1 chk("ready_before_first_edge", {aw_ready, ar_ready}, 2'b00);
      @(negedge clk);
      chk("ready_after_first_edge", {aw_ready, ar_ready}, 2'b11);

      // ---------------- INCR word burst, write then read back
      set_wr(3);
      tb_wd[0] = 32'h11111111; tb_wd[1] = 32'h22222222;
      tb_wd[2] = 32'h33333333; tb_wd[3] = 32'h44444444;
      do_write(32'h10, 8'd3, 3'd2, INCR, 0, wr_resp);
      chk("incr_write_bresp", wr_resp, 2'b00);
      do_read(32'h10, 8'd3, 3'd2, INCR, -1, 0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         chk("incr_read_data", rd_data[k], 32'h11111111 * (k + 1));
         chk("incr_read_resp", rd_resp[k], 2'b00);
         chk("incr_read_last", rd_last[k], (k == 3));
      end

      // ---------------- narrow unaligned write, byte reads
      set_wr(2);
      for (int k = 0; k < 3; k++) tb_wd[k] = 32'hAABBCCDD;
      do_write(32'h21, 8'd2, 3'd0, INCR, 0, wr_resp);
      chk("narrow_write_bresp", wr_resp, 2'b00);
      do_read(32'h22, 8'd0, 3'd0, INCR, -1, 0, 32'h0);
      chk("narrow_read_0x22", rd_data[0], 32'h00BB0000);
      chk("narrow_read_0x22_last", rd_last[0], 1'b1);
      do_read(32'h21, 8'd0, 3'd0, INCR, -1, 0, 32'h0);
      chk("narrow_read_0x21", rd_data[0], 32'h0000CC00);
      do_read(32'h23, 8'd0, 3'd0, INCR, -1, 0, 32'h0);
      chk("narrow_read_0x23", rd_data[0], 32'hAA000000);

      // ---------------- WRAP read over preloaded 0x30..0x3F
      set_wr(3);
      tb_wd[0] = 32'h30303030; tb_wd[1] = 32'h34343434;
      tb_wd[2] = 32'h38383838; tb_wd[3] = 32'h3C3C3C3C;
      do_write(32'h30, 8'd3, 3'd2, INCR, 0, wr_resp);
      chk("wrap_preload_bresp", wr_resp, 2'b00);
      do_read(32'h38, 8'd3, 3'd2, WRAP, -1, 0, 32'h0);
      chk("wrap_beat0", rd_data[0], 32'h38383838);
      chk("wrap_beat1", rd_data[1], 32'h3C3C3C3C);
      chk("wrap_beat2", rd_data[2], 32'h30303030);
      chk("wrap_beat3", rd_data[3], 32'h34343434);
      chk("wrap_resp0", rd_resp[0], 2'b00);
      chk("wrap_last3", rd_last[3], 1'b1);
      do_read(32'h38, 8'd2, 3'd2, WRAP, -1, 0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         chk("wrap_len2_resp", rd_resp[k], 2'b10);
         chk("wrap_len2_data", rd_data[k], 32'h0);
      end

      // ---------------- out-of-range second beat
      set_wr(1);
      tb_wd[0] = 32'hDEADBEEF; tb_wd[1] = 32'h01020304;
      do_write(32'hFC, 8'd1, 3'd2, INCR, 0, wr_resp);
      chk("oob_write_bresp", wr_resp, 2'b10);
      do_read(32'hFC, 8'd0, 3'd2, INCR, -1, 0, 32'h0);
      chk("oob_inrange_data", rd_data[0], 32'hDEADBEEF);
      chk("oob_inrange_resp", rd_resp[0], 2'b00);
      do_read(32'h100, 8'd0, 3'd2, INCR, -1, 0, 32'h0);
      chk("oob_read_resp", rd_resp[0], 2'b10);
      chk("oob_read_data", rd_data[0], 32'h0);

      // ---------------- misplaced w_last still writes
      set_wr(1);
      tb_wl[0] = 1'b1;
      tb_wd[0] = 32'h55555555; tb_wd[1] = 32'h66666666;
      do_write(32'h40, 8'd1, 3'd2, INCR, 0, wr_resp);
      chk("wlast_early_bresp", wr_resp, 2'b10);
      do_read(32'h40, 8'd1, 3'd2, INCR, -1, 0, 32'h0);
      chk("wlast_early_data0", rd_data[0], 32'h55555555);
      chk("wlast_early_data1", rd_data[1], 32'h66666666);

      // ---------------- backpressure on R and B
      do_read(32'h10, 8'd3, 3'd2, INCR, 1, 3, 32'h22222222);
      chk("bp_read_beat1", rd_data[1], 32'h22222222);
      chk("bp_read_beat2", rd_data[2], 32'h33333333);
      set_wr(0);
      tb_wd[0] = 32'h77777777;
      do_write(32'h50, 8'd0, 3'd2, INCR, 5, wr_resp);
      chk("bp_write_bresp", wr_resp, 2'b00);

      // ---------------- reset mid-burst
      aw_hs(32'h80, 8'd3, 3'd2, INCR);
      w_beat(32'h12345678, 4'hF, 1'b0);
      w_data = 32'h9ABCDEF0; w_strb = 4'hF; w_valid = 1'b1;
      #2 reset = 1'b0;
      #1 chk("midburst_reset_outputs", {aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last, r_resp, b_resp, r_data}, 64'd0);
      @(negedge clk);
      w_valid = 1'b0;
      reset = 1'b1;
      #1 chk("midburst_release_awready", aw_ready, 1'b0);
      @(negedge clk);
      chk("midburst_first_edge_awready", {aw_ready, w_ready}, 2'b10);
      do_read(32'h80, 8'd0, 3'd2, INCR, -1, 0, 32'h0);
      chk("midburst_beat0_retained", rd_data[0], 32'h12345678);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- Parametrised AXI4 slave memory model. Actively drives all slave-side handshakes (aw_ready, w_ready, b_valid/b_resp, ar_ready, r_valid/r_data/r_resp/r_last).
- Supports FIXED, INCR and WRAP bursts, narrow transfers with correct byte-lane mapping, and SLVERR reporting.
- Sits at the bottom of the AXI VIP environment as the responding memory for master-driven tests.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (32, 64 or 128).
- ADDR_WIDTH, 8, memory depth in bytes = 2**ADDR_WIDTH.
- STRB_WIDTH, DATA_WIDTH/8, byte lanes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- aw_addr in 32; aw_len in 8; aw_size in 3; aw_burst in 2; aw_valid in 1; aw_ready out 1.
- w_data in DATA_WIDTH; w_strb in STRB_WIDTH; w_last in 1; w_valid in 1; w_ready out 1.
- b_resp out 2; b_valid out 1; b_ready in 1.
- ar_addr in 32; ar_len in 8; ar_size in 3; ar_burst in 2; ar_valid in 1; ar_ready out 1.
- r_data out DATA_WIDTH; r_resp out 2; r_last out 1; r_valid out 1; r_ready in 1.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; both FSMs go to IDLE; beat counters 0.
  - Memory contents are NOT cleared and survive reset mid-burst; the in-flight burst is abandoned.
  - aw_ready and ar_ready rise at the first clk edge after reset deasserts.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: aw_ready=1. An AW handshake latches addr/len/size/burst; aw_ready=0 and w_ready=1 from the next cycle.
  - W_DATA: each w_valid&w_ready beat writes the enabled bytes at the clock edge. After beat aw_len: w_ready=0, b_valid=1 next cycle.
  - W_RESP: b_valid held until b_ready; then b_valid=0 and aw_ready=1 next cycle.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ar_ready=1. After an AR handshake at edge N: r_valid=1 from cycle N+1 with beat 0 registered.
  - R_DATA: each r_ready handshake loads the next beat for the following cycle, giving zero-bubble back-to-back beats.
  - r_last=1 only on beat ar_len. After the last handshake: r_valid=0, r_last=0, ar_ready=1 next cycle.
  - r_data, r_resp and r_last are stable while r_valid=1 and r_ready=0.
- Write and read channels are fully independent and concurrent.
- Address generation (beat address A_k, bytes per beat S = 2**size):
  - Start address is aligned down to S.
  - FIXED: A_k = A_0.
  - INCR: A_k = A_0 + k*S.
  - WRAP: total T = (len+1)*S; lower boundary = A_0 aligned down to T; address wraps to the boundary at boundary+T.
- Byte lanes:
  - Beat lane base = A_k mod STRB_WIDTH. Only lanes base..base+S-1 are active.
  - Write: byte j of the active lanes goes to mem[A_k+j] if w_strb[base+j]=1.
  - Read: active lanes carry mem[A_k+j]; inactive lanes are 0.
- Responses are OKAY=2'b00 or SLVERR=2'b10. SLVERR is raised for any of:
  - S > STRB_WIDTH;
  - burst=2'b11;
  - WRAP with len not in {1,3,7,15}, or with an unaligned start address;
  - any beat byte address >= 2**ADDR_WIDTH.
- SLVERR effects:
  - Write: the burst runs its full beat count with no memory update, and b_resp=SLVERR.
  - Read: every beat returns r_resp=SLVERR with r_data=0.
  - Out-of-range errors are evaluated per beat. In-range beats of the same write still update memory; b_resp is SLVERR if any beat erred.
- w_last handling:
  - Burst length is governed by the slave beat counter, not w_last.
  - If w_last does not equal (beat==aw_len) on any beat, b_resp=SLVERR. Data is still written.
- Same-cycle read/write to the same byte: the read beat captures the old data (read-first).

Test Plan:
- INCR write, DATA_WIDTH=32: aw_addr=0x10, len=3, size=2, data 0x11111111..0x44444444, strb=4'hF -> b_resp=0. An INCR read of the same burst returns the four words in order, with r_last only on beat 3.
- Narrow/unaligned write: aw_addr=0x21, size=0, INCR, len=2, w_data=0xAABBCCDD, strb=4'hF -> mem[0x21]=0xCC, mem[0x22]=0xBB, mem[0x23]=0xAA. A size=0 read at 0x22 returns r_data=0x00BB0000.
- WRAP read: ar_addr=0x38, size=2, len=3, memory preloaded -> beat addresses 0x38, 0x3C, 0x30, 0x34. WRAP with len=2 -> 3 beats, all r_resp=2'b10, r_data=0.
- Errors: write at aw_addr=0xFC, len=1, size=2 with ADDR_WIDTH=8 -> mem[0xFC..0xFF] written, beat 1 dropped, b_resp=2'b10. A write with w_last on beat 0 of len=1 -> b_resp=2'b10.
- Backpressure: r_ready low for 3 cycles mid-burst -> r_data held constant. b_ready low for 5 cycles -> b_valid held; aw_ready stays 0 until b_ready.
- Reset mid-burst: reset=0 during W_DATA beat 1 of 4 -> all outputs 0 immediately, beat 0 data retained in memory, aw_ready=1 on the first edge after release.
